// File: rtl/ekf_stage_sched_if.sv
// Handshake bundle between a stage requester / PE configurator and the EKF stage scheduler.
// The scheduler connects through the slave modport; the requester side uses master.
interface ekf_stage_sched_if #(
    parameter int unsigned LM_AW = 9
);
    logic [2:0]       req_val;
    logic [LM_AW-1:0] req_lm_id;
    logic             req_rdy;
    logic [2:0]       stage_val;
    logic [2:0]       stage_rdy;
    logic [LM_AW-1:0] cur_lm_id;
    logic [LM_AW-1:0] landmark_num;
    logic             done_val;
    logic [2:0]       done_stage;
    logic [1:0]       done_err;

    modport master (
        output req_val, req_lm_id, stage_rdy,
        input  req_rdy, stage_val, cur_lm_id, landmark_num, done_val, done_stage, done_err
    );

    modport slave (
        input  req_val, req_lm_id, stage_rdy,
        output req_rdy, stage_val, cur_lm_id, landmark_num, done_val, done_stage, done_err
    );
endinterface

// File: rtl/ekf_stage_sched.sv
// EKF stage scheduler: accepts PRD/NEW/UPD requests, issues one-hot stage commands to the
// PE configurator, tracks the landmark count and reports completion status.
// Optional stage watchdog is compiled in when STAGE_TIMEOUT_EN is defined.
module ekf_stage_sched #(
    parameter int unsigned MAX_LANDMARK = 500,
    parameter int unsigned LM_AW        = 9,
    parameter int unsigned TIMEOUT_CYC  = 4096
) (
    input logic              clk,
    input logic              sys_rst,
    ekf_stage_sched_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StDone} state_e;

    localparam logic [2:0] StgPrd = 3'b001;
    localparam logic [2:0] StgNew = 3'b010;
    localparam logic [2:0] StgUpd = 3'b100;

    localparam logic [1:0] ErrOk      = 2'b00;
    localparam logic [1:0] ErrFull    = 2'b01;
    localparam logic [1:0] ErrBadId   = 2'b10;
    localparam logic [1:0] ErrTimeout = 2'b11;

    localparam logic [LM_AW-1:0] MaxLm = LM_AW'(MAX_LANDMARK);

    state_e           state_q, state_d;
    logic [2:0]       stage_q, stage_d;
    logic [LM_AW-1:0] lm_id_q, lm_id_d;
    logic [1:0]       err_q, err_d;
    logic [LM_AW-1:0] landmark_num_q, landmark_num_d;
    logic             accept;

`ifdef STAGE_TIMEOUT_EN
    localparam int unsigned CntW = ($clog2(TIMEOUT_CYC) > 0) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);
    logic [CntW-1:0] cnt_q, cnt_d;
`else
    // Watchdog limit has no effect in this build.
    logic unused_timeout_cyc;
    assign unused_timeout_cyc = ^TIMEOUT_CYC;
`endif

    // Only all-ready counts as ready; mixed status codes are treated as busy.
    assign bus.req_rdy      = (state_q == StIdle) && (bus.stage_rdy == 3'b111) && !sys_rst;
    assign accept           = bus.req_rdy && (bus.req_val != 3'b000);
    assign bus.stage_val    = (state_q == StIssue) ? stage_q : 3'b000;
    assign bus.cur_lm_id    = lm_id_q;
    assign bus.landmark_num = landmark_num_q;
    assign bus.done_val     = (state_q == StDone);
    assign bus.done_stage   = (state_q == StDone) ? stage_q : 3'b000;
    assign bus.done_err     = (state_q == StDone) ? err_q : ErrOk;

    // Next-state: request selection and validation, issue handshake, completion bookkeeping.
    always_comb begin
        state_d        = state_q;
        stage_d        = stage_q;
        lm_id_d        = lm_id_q;
        err_d          = err_q;
        landmark_num_d = landmark_num_q;
`ifdef STAGE_TIMEOUT_EN
        cnt_d          = cnt_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (accept) begin
`ifdef STAGE_TIMEOUT_EN
                    cnt_d = '0;
`endif
                    // Fixed priority PRD > NEW > UPD; losing requests are dropped.
                    if (bus.req_val[0]) begin
                        stage_d = StgPrd;
                        lm_id_d = '0;
                        err_d   = ErrOk;
                        state_d = StIssue;
                    end else if (bus.req_val[1]) begin
                        stage_d = StgNew;
                        lm_id_d = landmark_num_q;
                        if (landmark_num_q == MaxLm) begin
                            err_d   = ErrFull;
                            state_d = StDone;
                        end else begin
                            err_d   = ErrOk;
                            state_d = StIssue;
                        end
                    end else begin
                        stage_d = StgUpd;
                        lm_id_d = bus.req_lm_id;
                        if (bus.req_lm_id >= landmark_num_q) begin
                            err_d   = ErrBadId;
                            state_d = StDone;
                        end else begin
                            err_d   = ErrOk;
                            state_d = StIssue;
                        end
                    end
                end
            end
            StIssue: begin
                if (bus.stage_rdy == 3'b000) state_d = StWait;
            end
            StWait: begin
                if (bus.stage_rdy == 3'b111) state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
                if (stage_q == StgNew && err_q == ErrOk && landmark_num_q != MaxLm) begin
                    landmark_num_d = landmark_num_q + LM_AW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
`ifdef STAGE_TIMEOUT_EN
        // Watchdog covers the whole ISSUE+WAIT span and overrides the handshake.
        if (state_q == StIssue || state_q == StWait) begin
            cnt_d = cnt_q + CntW'(1);
            if (cnt_q == CntLast) begin
                state_d = StDone;
                err_d   = ErrTimeout;
            end
        end
`endif
    end

    // State register with synchronous reset; reset aborts any stage in flight.
    always_ff @(posedge clk) begin
        if (sys_rst) begin
            state_q        <= StIdle;
            stage_q        <= 3'b000;
            lm_id_q        <= '0;
            err_q          <= ErrOk;
            landmark_num_q <= '0;
`ifdef STAGE_TIMEOUT_EN
            cnt_q          <= '0;
`endif
        end else begin
            state_q        <= state_d;
            stage_q        <= stage_d;
            lm_id_q        <= lm_id_d;
            err_q          <= err_d;
            landmark_num_q <= landmark_num_d;
`ifdef STAGE_TIMEOUT_EN
            cnt_q          <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_ekf_stage_sched.sv
// Directed bench for ekf_stage_sched: a default-size instance and a two-landmark instance.
module tb_ekf_stage_sched;

    logic clk = 1'b0;
    logic sys_rst = 1'b1;
    always #5 clk = ~clk;

    ekf_stage_sched_if #(.LM_AW(9)) bif ();
    ekf_stage_sched_if #(.LM_AW(9)) sif ();

    ekf_stage_sched #(.MAX_LANDMARK(500), .LM_AW(9), .TIMEOUT_CYC(16)) u_dut (
        .clk     (clk),
        .sys_rst (sys_rst),
        .bus     (bif)
    );

    ekf_stage_sched #(.MAX_LANDMARK(2), .LM_AW(9), .TIMEOUT_CYC(16)) u_dut_small (
        .clk     (clk),
        .sys_rst (sys_rst),
        .bus     (sif)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One complete request on the selected instance; returns what was observed.
    task automatic do_req(input bit sel, input logic [2:0] rv, input logic [8:0] id,
                          output logic [2:0] stg, output logic [8:0] lm,
                          output logic got_done, output logic [2:0] dstg,
                          output logic [1:0] derr);
        if (sel) begin sif.req_val = rv; sif.req_lm_id = id; end
        else     begin bif.req_val = rv; bif.req_lm_id = id; end
        tick;
        bif.req_val = 3'b000;
        sif.req_val = 3'b000;
        stg = sel ? sif.stage_val : bif.stage_val;
        lm  = sel ? sif.cur_lm_id : bif.cur_lm_id;
        if (stg != 3'b000) begin
            if (sel) sif.stage_rdy = 3'b000; else bif.stage_rdy = 3'b000;
            tick;
            if (sel) sif.stage_rdy = 3'b111; else bif.stage_rdy = 3'b111;
            tick;
        end
        got_done = sel ? sif.done_val : bif.done_val;
        dstg     = sel ? sif.done_stage : bif.done_stage;
        derr     = sel ? sif.done_err : bif.done_err;
        tick;
    endtask

    task automatic test_reset;
        sys_rst = 1'b1;
        tick;
        tick;
        n_checks++; if (bif.req_rdy !== 1'b0) begin n_fail++; $display("FAIL rst_req_rdy got %b want 0", bif.req_rdy); end
        n_checks++; if (bif.stage_val !== 3'b000) begin n_fail++; $display("FAIL rst_stage_val got %b want 000", bif.stage_val); end
        n_checks++; if (bif.cur_lm_id !== 9'd0) begin n_fail++; $display("FAIL rst_cur_lm_id got %0d want 0", bif.cur_lm_id); end
        n_checks++; if (bif.landmark_num !== 9'd0) begin n_fail++; $display("FAIL rst_landmark_num got %0d want 0", bif.landmark_num); end
        n_checks++; if (bif.done_val !== 1'b0) begin n_fail++; $display("FAIL rst_done_val got %b want 0", bif.done_val); end
        n_checks++; if (bif.done_stage !== 3'b000) begin n_fail++; $display("FAIL rst_done_stage got %b want 000", bif.done_stage); end
        n_checks++; if (bif.done_err !== 2'b00) begin n_fail++; $display("FAIL rst_done_err got %b want 00", bif.done_err); end
        sys_rst = 1'b0;
        #1;
        n_checks++; if (bif.req_rdy !== 1'b1) begin n_fail++; $display("FAIL post_rst_req_rdy got %b want 1", bif.req_rdy); end
    endtask

    task automatic test_prd;
        bif.req_val = 3'b001;
        tick;
        bif.req_val = 3'b000;
        n_checks++; if (bif.stage_val !== 3'b001) begin n_fail++; $display("FAIL prd_issue got %b want 001", bif.stage_val); end
        tick;
        n_checks++; if (bif.stage_val !== 3'b001) begin n_fail++; $display("FAIL prd_hold got %b want 001", bif.stage_val); end
        bif.stage_rdy = 3'b000;
        tick;
        n_checks++; if (bif.stage_val !== 3'b000) begin n_fail++; $display("FAIL prd_wait_stage got %b want 000", bif.stage_val); end
        n_checks++; if (bif.done_val !== 1'b0) begin n_fail++; $display("FAIL prd_wait_done got %b want 0", bif.done_val); end
        bif.stage_rdy = 3'b111;
        tick;
        n_checks++; if (bif.done_val !== 1'b1) begin n_fail++; $display("FAIL prd_done_val got %b want 1", bif.done_val); end
        n_checks++; if (bif.done_stage !== 3'b001) begin n_fail++; $display("FAIL prd_done_stage got %b want 001", bif.done_stage); end
        n_checks++; if (bif.done_err !== 2'b00) begin n_fail++; $display("FAIL prd_done_err got %b want 00", bif.done_err); end
        n_checks++; if (bif.req_rdy !== 1'b0) begin n_fail++; $display("FAIL prd_done_req_rdy got %b want 0", bif.req_rdy); end
        tick;
        n_checks++; if (bif.done_val !== 1'b0) begin n_fail++; $display("FAIL prd_done_pulse got %b want 0", bif.done_val); end
        n_checks++; if (bif.req_rdy !== 1'b1) begin n_fail++; $display("FAIL prd_idle_req_rdy got %b want 1", bif.req_rdy); end
    endtask

    task automatic test_priority;
        logic [2:0] stg, dstg;
        logic [8:0] lm;
        logic       gd;
        logic [1:0] derr;
        do_req(1'b0, 3'b111, 9'd0, stg, lm, gd, dstg, derr);
        n_checks++; if (stg !== 3'b001) begin n_fail++; $display("FAIL prio_stage got %b want 001", stg); end
        n_checks++; if (dstg !== 3'b001) begin n_fail++; $display("FAIL prio_done_stage got %b want 001", dstg); end
        n_checks++; if (bif.landmark_num !== 9'd0) begin n_fail++; $display("FAIL prio_landmark got %0d want 0", bif.landmark_num); end
        n_checks++; if (bif.stage_val !== 3'b000) begin n_fail++; $display("FAIL prio_no_queue got %b want 000", bif.stage_val); end
    endtask

    task automatic test_landmarks;
        logic [2:0] stg, dstg;
        logic [8:0] lm;
        logic       gd;
        logic [1:0] derr;
        for (int i = 0; i < 3; i++) begin
            do_req(1'b0, 3'b010, 9'd0, stg, lm, gd, dstg, derr);
            n_checks++; if (stg !== 3'b010) begin n_fail++; $display("FAIL new%0d_stage got %b want 010", i, stg); end
            n_checks++; if (lm !== 9'(i)) begin n_fail++; $display("FAIL new%0d_cur_lm_id got %0d want %0d", i, lm, i); end
            n_checks++; if (derr !== 2'b00) begin n_fail++; $display("FAIL new%0d_err got %b want 00", i, derr); end
            n_checks++; if (bif.landmark_num !== 9'(i + 1)) begin n_fail++; $display("FAIL new%0d_landmark got %0d want %0d", i, bif.landmark_num, i + 1); end
        end
        do_req(1'b0, 3'b100, 9'd3, stg, lm, gd, dstg, derr);
        n_checks++; if (stg !== 3'b000) begin n_fail++; $display("FAIL upd_bad_stage got %b want 000", stg); end
        n_checks++; if (gd !== 1'b1) begin n_fail++; $display("FAIL upd_bad_done got %b want 1", gd); end
        n_checks++; if (dstg !== 3'b100) begin n_fail++; $display("FAIL upd_bad_done_stage got %b want 100", dstg); end
        n_checks++; if (derr !== 2'b10) begin n_fail++; $display("FAIL upd_bad_err got %b want 10", derr); end
        do_req(1'b0, 3'b100, 9'd2, stg, lm, gd, dstg, derr);
        n_checks++; if (stg !== 3'b100) begin n_fail++; $display("FAIL upd_ok_stage got %b want 100", stg); end
        n_checks++; if (lm !== 9'd2) begin n_fail++; $display("FAIL upd_ok_cur_lm_id got %0d want 2", lm); end
        n_checks++; if (derr !== 2'b00) begin n_fail++; $display("FAIL upd_ok_err got %b want 00", derr); end
        n_checks++; if (bif.landmark_num !== 9'd3) begin n_fail++; $display("FAIL upd_ok_landmark got %0d want 3", bif.landmark_num); end
    endtask

    task automatic test_busy_codes;
        bif.req_val = 3'b001;
        tick;
        bif.req_val = 3'b010;
        bif.stage_rdy = 3'b010;
        tick;
        n_checks++; if (bif.stage_val !== 3'b001) begin n_fail++; $display("FAIL busy_issue_hold got %b want 001", bif.stage_val); end
        n_checks++; if (bif.req_rdy !== 1'b0) begin n_fail++; $display("FAIL busy_req_rdy got %b want 0", bif.req_rdy); end
        bif.stage_rdy = 3'b000;
        tick;
        bif.stage_rdy = 3'b101;
        tick;
        tick;
        n_checks++; if (bif.done_val !== 1'b0) begin n_fail++; $display("FAIL busy_wait_hold got %b want 0", bif.done_val); end
        bif.req_val = 3'b000;
        bif.stage_rdy = 3'b111;
        tick;
        n_checks++; if (bif.done_stage !== 3'b001) begin n_fail++; $display("FAIL busy_done_stage got %b want 001", bif.done_stage); end
        tick;
        n_checks++; if (bif.landmark_num !== 9'd3) begin n_fail++; $display("FAIL busy_landmark got %0d want 3", bif.landmark_num); end
    endtask

    task automatic test_full;
        logic [2:0] stg, dstg;
        logic [8:0] lm;
        logic       gd;
        logic [1:0] derr;
        for (int i = 0; i < 2; i++) begin
            do_req(1'b1, 3'b010, 9'd0, stg, lm, gd, dstg, derr);
            n_checks++; if (derr !== 2'b00) begin n_fail++; $display("FAIL full_new%0d_err got %b want 00", i, derr); end
        end
        do_req(1'b1, 3'b010, 9'd0, stg, lm, gd, dstg, derr);
        n_checks++; if (stg !== 3'b000) begin n_fail++; $display("FAIL full_stage got %b want 000", stg); end
        n_checks++; if (dstg !== 3'b010) begin n_fail++; $display("FAIL full_done_stage got %b want 010", dstg); end
        n_checks++; if (derr !== 2'b01) begin n_fail++; $display("FAIL full_err got %b want 01", derr); end
        n_checks++; if (sif.landmark_num !== 9'd2) begin n_fail++; $display("FAIL full_landmark got %0d want 2", sif.landmark_num); end
    endtask

    task automatic test_timeout;
        int   cyc;
        logic seen;
        logic [1:0] derr;
        cyc  = 0;
        seen = 1'b0;
        derr = 2'b00;
        bif.req_val = 3'b001;
        tick;
        bif.req_val = 3'b000;
        bif.stage_rdy = 3'b000;
        for (int n = 1; n <= 40; n++) begin
            tick;
            if (!seen && bif.done_val) begin
                seen = 1'b1;
                cyc  = n;
                derr = bif.done_err;
            end
        end
`ifdef STAGE_TIMEOUT_EN
        n_checks++; if (seen !== 1'b1) begin n_fail++; $display("FAIL tmo_done got %b want 1", seen); end
        n_checks++; if (cyc != 16) begin n_fail++; $display("FAIL tmo_cycles got %0d want 16", cyc); end
        n_checks++; if (derr !== 2'b11) begin n_fail++; $display("FAIL tmo_err got %b want 11", derr); end
        bif.stage_rdy = 3'b111;
        tick;
`else
        n_checks++; if (seen !== 1'b0) begin n_fail++; $display("FAIL notmo_done got %b want 0 (err %b)", seen, derr); end
        n_checks++; if (bif.stage_val !== 3'b000) begin n_fail++; $display("FAIL notmo_stage got %b want 000", bif.stage_val); end
        bif.stage_rdy = 3'b111;
        tick;
        n_checks++; if (bif.done_err !== 2'b00 || bif.done_val !== 1'b1) begin n_fail++; $display("FAIL notmo_finish got val %b err %b want 1 00", bif.done_val, bif.done_err); end
        tick;
`endif
        n_checks++; if (bif.landmark_num !== 9'd3) begin n_fail++; $display("FAIL tmo_landmark got %0d want 3", bif.landmark_num); end
    endtask

    task automatic test_reset_mid;
        logic [2:0] stg, dstg;
        logic [8:0] lm;
        logic       gd;
        logic [1:0] derr;
        bif.req_val = 3'b001;
        tick;
        bif.req_val = 3'b000;
        bif.stage_rdy = 3'b000;
        tick;
        sys_rst = 1'b1;
        bif.stage_rdy = 3'b111;
        tick;
        n_checks++; if (bif.stage_val !== 3'b000) begin n_fail++; $display("FAIL mid_rst_stage got %b want 000", bif.stage_val); end
        n_checks++; if (bif.landmark_num !== 9'd0) begin n_fail++; $display("FAIL mid_rst_landmark got %0d want 0", bif.landmark_num); end
        n_checks++; if (bif.done_val !== 1'b0) begin n_fail++; $display("FAIL mid_rst_done got %b want 0", bif.done_val); end
        n_checks++; if (bif.req_rdy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_req_rdy got %b want 0", bif.req_rdy); end
        sys_rst = 1'b0;
        tick;
        n_checks++; if (bif.done_val !== 1'b0) begin n_fail++; $display("FAIL mid_rst_after_done got %b want 0", bif.done_val); end
        do_req(1'b0, 3'b010, 9'd0, stg, lm, gd, dstg, derr);
        n_checks++; if (stg !== 3'b010) begin n_fail++; $display("FAIL mid_rst_new_stage got %b want 010", stg); end
        n_checks++; if (lm !== 9'd0) begin n_fail++; $display("FAIL mid_rst_new_lm got %0d want 0", lm); end
        n_checks++; if (bif.landmark_num !== 9'd1) begin n_fail++; $display("FAIL mid_rst_new_landmark got %0d want 1", bif.landmark_num); end
    endtask

    initial begin
        bif.req_val = 3'b000; bif.req_lm_id = 9'd0; bif.stage_rdy = 3'b111;
        sif.req_val = 3'b000; sif.req_lm_id = 9'd0; sif.stage_rdy = 3'b111;
        test_reset;
        test_prd;
        test_priority;
        test_landmarks;
        test_busy_codes;
        test_full;
        test_timeout;
        test_reset_mid;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
